// File: rtl/io_map_pkg.sv
// Address map, status bit positions and register-select decode shared by the IO controller.
package io_map_pkg;

    localparam int DW = 8;

    localparam logic [7:0] ADDR_OUT_DATA = 8'h00;
    localparam logic [7:0] ADDR_OUT_STAT = 8'h04;
    localparam logic [7:0] ADDR_IN_DATA  = 8'h0C;
    localparam logic [7:0] ADDR_IN_VALID = 8'h10;
    localparam logic [7:0] ADDR_CYCLES   = 8'h14;

    localparam int STAT_NFULL_BIT = 0;
    localparam int STAT_OVF_BIT   = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_OUT_DATA,
        SEL_OUT_STAT,
        SEL_IN_DATA,
        SEL_IN_VALID,
        SEL_CYCLES
    } io_sel_e;

    // Caller passes a word-aligned address (byte offset bits already zeroed).
    function automatic io_sel_e io_decode(input logic [7:0] addr);
        case (addr)
            ADDR_OUT_DATA: return SEL_OUT_DATA;
            ADDR_OUT_STAT: return SEL_OUT_STAT;
            ADDR_IN_DATA:  return SEL_IN_DATA;
            ADDR_IN_VALID: return SEL_IN_VALID;
            ADDR_CYCLES:   return SEL_CYCLES;
            default:       return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Small flop-based FIFO with a combinational head; head reads 0 while empty.
module io_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_mmio_ctrl.sv
// CPU memory-mapped IO controller: one-byte input holding register, output FIFO, overflow flag.
// Optional free-running cycle counter at 0x14 when IO_CYCLE_COUNTER_EN is defined.
module io_mmio_ctrl
    import io_map_pkg::*;
#(
    parameter int OUT_DEPTH = 4,
    parameter int DW        = io_map_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    io_addr,
    input  logic [31:0]   io_dout,
    input  logic          io_we,
    input  logic          io_re,
    output logic [31:0]   io_din,
    input  logic [DW-1:0] in_dev_data,
    input  logic          in_dev_valid,
    output logic          in_dev_ready,
    output logic [DW-1:0] out_dev_data,
    output logic          out_dev_valid,
    input  logic          out_dev_ready
);
    io_sel_e       w_sel;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    logic [31:0]   w_din;
    logic          w_unused_bits;
    logic          r_in_full;
    logic [DW-1:0] r_in_reg;
    logic          r_ovf;

    assign w_sel         = io_decode({io_addr[7:2], 2'b00});
    assign w_push        = io_we && (w_sel == SEL_OUT_DATA);
    assign w_pop         = out_dev_valid && out_dev_ready;
    assign w_drop        = w_push && w_full && !w_pop;
    assign w_unused_bits = ^{io_addr[1:0], io_dout[31:DW]};

    io_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (DW)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (io_dout[DW-1:0]),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (out_dev_data)
    );

    assign out_dev_valid = !w_empty;
    assign in_dev_ready  = !r_in_full;

    // Capture and pop never collide: ready is low for as long as the byte is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_full <= 1'b0;
            r_in_reg  <= '0;
        end else if (in_dev_valid && !r_in_full) begin
            r_in_full <= 1'b1;
            r_in_reg  <= in_dev_data;
        end else if (io_re && (w_sel == SEL_IN_DATA)) begin
            r_in_full <= 1'b0;
        end
    end

    // Sticky overflow; a drop on the same edge as the clearing read keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (io_re && (w_sel == SEL_OUT_STAT)) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycles <= '0;
        end else if (io_we && (w_sel == SEL_CYCLES)) begin
            r_cycles <= io_dout;
        end else begin
            r_cycles <= r_cycles + 32'd1;
        end
    end
`endif

    always_comb begin
        w_din = '0;
        case (w_sel)
            SEL_OUT_STAT: begin
                w_din[STAT_OVF_BIT]   = r_ovf;
                w_din[STAT_NFULL_BIT] = !w_full;
            end
            SEL_IN_DATA: begin
                if (r_in_full) w_din[DW-1:0] = r_in_reg;
            end
            SEL_IN_VALID: begin
                w_din[0] = r_in_full;
            end
            SEL_CYCLES: begin
`ifdef IO_CYCLE_COUNTER_EN
                w_din = r_cycles;
`else
                w_din = '0;
`endif
            end
            default: w_din = '0;
        endcase
    end

    assign io_din = w_din;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Randomized bench for io_mmio_ctrl against a queue-based model, plus directed scenarios.
module tb_io_mmio_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  io_addr = '0;
    logic [31:0] io_dout = '0;
    logic        io_we = 1'b0;
    logic        io_re = 1'b0;
    logic [31:0] io_din;
    logic [7:0]  in_dev_data = '0;
    logic        in_dev_valid = 1'b0;
    logic        in_dev_ready;
    logic [7:0]  out_dev_data;
    logic        out_dev_valid;
    logic        out_dev_ready = 1'b0;

    int total = 0;
    int bad = 0;

    io_mmio_ctrl #(.OUT_DEPTH(DEPTH), .DW(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .io_addr       (io_addr),
        .io_dout       (io_dout),
        .io_we         (io_we),
        .io_re         (io_re),
        .io_din        (io_din),
        .in_dev_data   (in_dev_data),
        .in_dev_valid  (in_dev_valid),
        .in_dev_ready  (in_dev_ready),
        .out_dev_data  (out_dev_data),
        .out_dev_valid (out_dev_valid),
        .out_dev_ready (out_dev_ready)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0]  m_q[$];
    bit          m_in_full = 0;
    logic [7:0]  m_in_byte = '0;
    bit          m_ovf = 0;
    logic [31:0] m_cnt = '0;

    task automatic model_clear();
        m_q.delete();
        m_in_full = 0;
        m_in_byte = '0;
        m_ovf = 0;
        m_cnt = '0;
    endtask

    function automatic logic [31:0] exp_din(input logic [7:0] a);
        logic [7:0] w;
        w = {a[7:2], 2'b00};
        case (w)
            8'h04:   return {30'b0, m_ovf, (m_q.size() != DEPTH)};
            8'h0C:   return m_in_full ? {24'b0, m_in_byte} : 32'd0;
            8'h10:   return {31'b0, m_in_full};
`ifdef IO_CYCLE_COUNTER_EN
            8'h14:   return m_cnt;
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge rst) model_clear();

    always @(posedge clk) begin : mdl
        bit pop, push, drop;
        logic [7:0] w;
        if (!rst) begin
            model_clear();
        end else begin
            w = {io_addr[7:2], 2'b00};
            if (in_dev_valid && !m_in_full) begin
                m_in_full = 1;
                m_in_byte = in_dev_data;
            end else if (io_re && w == 8'h0C) begin
                m_in_full = 0;
            end
            pop  = (m_q.size() > 0) && out_dev_ready;
            push = io_we && (w == 8'h00);
            drop = push && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (push && !drop) m_q.push_back(io_dout[7:0]);
            if (drop) m_ovf = 1;
            else if (io_re && w == 8'h04) m_ovf = 0;
            if (io_we && w == 8'h14) m_cnt = io_dout;
            else m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model away from the active edge
    always @(negedge clk) begin
        check("in_dev_ready", {31'b0, in_dev_ready}, {31'b0, !m_in_full});
        check("out_dev_valid", {31'b0, out_dev_valid}, {31'b0, m_q.size() > 0});
        check("out_dev_data", {24'b0, out_dev_data}, (m_q.size() > 0) ? {24'b0, m_q[0]} : 32'd0);
        check("io_din", io_din, exp_din(io_addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [7:0] a, input logic [31:0] exp, input string name);
        io_we = 0;
        io_re = 0;
        io_addr = a;
        #1;
        check(name, io_din, exp);
    endtask

    task automatic push(input logic [7:0] b);
        io_addr = 8'h00;
        io_dout = {24'hABCDEF, b};
        io_we = 1;
        tick();
        io_we = 0;
    endtask

    initial begin
        logic [7:0] last;
        logic [7:0] addrs [7];
        addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h0C; addrs[3] = 8'h10;
        addrs[4] = 8'h14; addrs[5] = 8'h0D; addrs[6] = 8'h08;

        // Reset state
        repeat (3) tick();
        rst = 1;
        tick();
        check("rst_ready", {31'b0, in_dev_ready}, 32'd1);
        check("rst_valid", {31'b0, out_dev_valid}, 32'd0);
        peek(8'h10, 32'd0, "rst_in_valid");
        peek(8'h0C, 32'd0, "rst_in_data");

        // Input byte capture and pop
        in_dev_data = 8'h5A;
        in_dev_valid = 1;
        tick();
        in_dev_valid = 0;
        check("in_ready_low", {31'b0, in_dev_ready}, 32'd0);
        peek(8'h10, 32'd1, "in_valid_set");
        peek(8'h0C, 32'h5A, "in_data");
        io_addr = 8'h0C;
        io_re = 1;
        tick();
        io_re = 0;
        peek(8'h10, 32'd0, "in_valid_clr");
        check("in_ready_back", {31'b0, in_dev_ready}, 32'd1);

        // Overflow on fifth push, then drain
        out_dev_ready = 0;
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        peek(8'h04, 32'h2, "stat_ovf_full");
        out_dev_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", {24'b0, out_dev_data}, 32'h11 + i);
            tick();
        end
        check("drained_valid", {31'b0, out_dev_valid}, 32'd0);
        io_addr = 8'h04;
        io_re = 1;
        tick();
        io_re = 0;
        peek(8'h04, 32'h1, "stat_ovf_clr");

        // Full FIFO, push and pop on the same edge
        out_dev_ready = 0;
        for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
        out_dev_ready = 1;
        push(8'h77);
        peek(8'h04, 32'h0, "full_pushpop_no_ovf");
        last = '0;
        for (int i = 0; i < 4; i++) begin
            last = out_dev_data;
            tick();
        end
        check("last_emitted", {24'b0, last}, 32'h77);
        check("empty_after", {31'b0, out_dev_valid}, 32'd0);

        // Asynchronous reset mid-drain
        out_dev_ready = 0;
        for (int i = 0; i < 5; i++) push(8'hA1 + 8'(i));
        out_dev_ready = 1;
        tick();
        rst = 0;
        #1;
        check("rst_mid_valid", {31'b0, out_dev_valid}, 32'd0);
        peek(8'h04, 32'h1, "rst_mid_stat");
        rst = 1;
        out_dev_ready = 0;
        tick();

        // Cycle counter
`ifdef IO_CYCLE_COUNTER_EN
        io_addr = 8'h14;
        io_dout = 32'hFFFF_FFFE;
        io_we = 1;
        tick();
        io_we = 0;
        peek(8'h14, 32'hFFFF_FFFE, "cnt_load");
        tick();
        peek(8'h14, 32'hFFFF_FFFF, "cnt_max");
        tick();
        peek(8'h14, 32'h0, "cnt_wrap");
`else
        io_addr = 8'h14;
        io_dout = 32'h1234_5678;
        io_we = 1;
        tick();
        io_we = 0;
        peek(8'h14, 32'h0, "cnt_absent");
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            io_addr = ($urandom_range(0, 9) < 8) ? addrs[$urandom_range(0, 6)] : 8'($urandom);
            io_dout = $urandom;
            io_we = ($urandom_range(0, 2) == 0);
            io_re = ($urandom_range(0, 2) == 0);
            in_dev_data = 8'($urandom);
            in_dev_valid = ($urandom_range(0, 1) == 1);
            out_dev_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 0;
                #2 rst = 1;
            end
            tick();
        end

        io_we = 0;
        io_re = 0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
